jk_by_d: RTL and testbench

JK_BY_D -- requirements
Module: jk_by_D

---
 rtl/jk_by_d.sv | 33 +++
 tb/tb_jk_by_d.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_by_d.sv
// JK flip-flop built from one D flip-flop.
// Next-state logic feeds D as D = (j & ~q) | (~k & q).
module jk_by_d #(
  parameter logic RESET_Q = 1'b0
) (
  output logic q,
  output logic qbar,
  input  logic j,
  input  logic k,
  input  logic rst_n,
  input  logic clk
);

  logic w_d;
  logic r_q;

  // JK characteristic equation: set when low, keep unless k when high.
  always_comb begin
    w_d = (j & ~r_q) | (~k & r_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= RESET_Q;
    end else begin
      r_q <= w_d;
    end
  end

  assign q    = r_q;
  assign qbar = ~r_q;

endmodule

// File: tb/tb_jk_by_d.sv
// Self-checking bench for jk_by_d: a truth-table model pushes expected q per edge,
// and each task pops and compares after the edge.
module tb_jk_by_d;

  logic clk;
  logic rst_n;
  logic j;
  logic k;
  logic q;
  logic qbar;

  int unsigned n_tests;
  int unsigned n_fail;
  logic        m_q;
  logic        exp_q[$];

  jk_by_d #(.RESET_Q(1'b0)) dut (
    .q     (q),
    .qbar  (qbar),
    .j     (j),
    .k     (k),
    .rst_n (rst_n),
    .clk   (clk)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  function automatic logic model_next(input logic cq, input logic cj, input logic ck);
    case ({cj, ck})
      2'b00:   return cq;
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      default: return ~cq;
    endcase
  endfunction

  task automatic push_edge(input logic jv, input logic kv);
    j   = jv;
    k   = kv;
    m_q = model_next(m_q, jv, kv);
    exp_q.push_back(m_q);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    j     = 1'b1;
    k     = 1'b1;
    m_q   = 1'b0;
    #51;
    n_tests++;
    if (q !== 1'b0 || qbar !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_t51: q=%b qbar=%b, required q=0 qbar=1", q, qbar);
    end
    #48;
    n_tests++;
    if (q !== 1'b0 || qbar !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_t99: q=%b qbar=%b, required q=0 qbar=1", q, qbar);
    end
    @(negedge clk);
  endtask

  task automatic test_pattern();
    logic e;
    for (int n = 1; n <= 9; n++) begin
      rst_n = 1'b1;
      push_edge(logic'(n % 2 == 0), logic'((n / 2) % 2 == 0));
      @(posedge clk);
      #1;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pattern_edge%0d: scoreboard empty", n);
      end else begin
        e = exp_q.pop_front();
        if (q !== e || qbar !== ~e) begin
          n_fail++;
          $display("FAIL pattern_edge%0d: q=%b qbar=%b, required q=%b qbar=%b",
                   n, q, qbar, e, ~e);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_toggle_hold();
    logic e;
    for (int n = 0; n < 3; n++) begin
      push_edge(1'b1, 1'b1);
      @(posedge clk);
      #1;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL toggle_%0d: scoreboard empty", n);
      end else begin
        e = exp_q.pop_front();
        if (q !== e || qbar !== ~e) begin
          n_fail++;
          $display("FAIL toggle_%0d: q=%b qbar=%b, required q=%b qbar=%b",
                   n, q, qbar, e, ~e);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_between_edges();
    logic e;
    logic held;
    push_edge(1'b0, 1'b0);
    @(posedge clk);
    #1;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL hold_edge: scoreboard empty");
    end else begin
      e = exp_q.pop_front();
      if (q !== e || qbar !== ~e) begin
        n_fail++;
        $display("FAIL hold_edge: q=%b qbar=%b, required q=%b qbar=%b", q, qbar, e, ~e);
      end
    end
    held = m_q;
    for (int n = 0; n < 4; n++) begin
      #10;
      j = n[0];
      k = ~n[1];
      #1;
      n_tests++;
      if (q !== held || qbar !== ~held) begin
        n_fail++;
        $display("FAIL between_edges_%0d: q=%b qbar=%b, required q=%b qbar=%b",
                 n, q, qbar, held, ~held);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    logic e;
    push_edge(1'b1, 1'b0);
    @(posedge clk);
    #1;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL set_before_reset: scoreboard empty");
    end else begin
      e = exp_q.pop_front();
      if (q !== e || qbar !== ~e) begin
        n_fail++;
        $display("FAIL set_before_reset: q=%b qbar=%b, required q=%b qbar=%b",
                 q, qbar, e, ~e);
      end
    end
    #20;
    rst_n = 1'b0;
    m_q   = 1'b0;
    #1;
    n_tests++;
    if (q !== 1'b0 || qbar !== 1'b1) begin
      n_fail++;
      $display("FAIL async_assert: q=%b qbar=%b, required q=0 qbar=1", q, qbar);
    end
    j = 1'b1;
    k = 1'b0;
    @(posedge clk);
    #1;
    n_tests++;
    if (q !== 1'b0 || qbar !== 1'b1) begin
      n_fail++;
      $display("FAIL edge_in_reset: q=%b qbar=%b, required q=0 qbar=1", q, qbar);
    end
    @(negedge clk);
    #10;
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (q !== 1'b0 || qbar !== 1'b1) begin
      n_fail++;
      $display("FAIL release_no_edge: q=%b qbar=%b, required q=0 qbar=1", q, qbar);
    end
    push_edge(1'b1, 1'b0);
    @(posedge clk);
    #1;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL first_edge_after_release: scoreboard empty");
    end else begin
      e = exp_q.pop_front();
      if (q !== e || qbar !== ~e) begin
        n_fail++;
        $display("FAIL first_edge_after_release: q=%b qbar=%b, required q=%b qbar=%b",
                 q, qbar, e, ~e);
      end
    end
    @(negedge clk);
    j = 1'b1;
    k = 1'b1;
    #20;
    rst_n = 1'b0;
    m_q   = 1'b0;
    #1;
    n_tests++;
    if (q !== 1'b0 || qbar !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_over_toggle: q=%b qbar=%b, required q=0 qbar=1", q, qbar);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (q !== 1'b0 || qbar !== 1'b1) begin
      n_fail++;
      $display("FAIL toggle_edge_in_reset: q=%b qbar=%b, required q=0 qbar=1", q, qbar);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 2; n++) begin
      push_edge(1'b1, 1'b1);
      @(posedge clk);
      #1;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL post_reset_toggle_%0d: scoreboard empty", n);
      end else begin
        e = exp_q.pop_front();
        if (q !== e || qbar !== ~e) begin
          n_fail++;
          $display("FAIL post_reset_toggle_%0d: q=%b qbar=%b, required q=%b qbar=%b",
                   n, q, qbar, e, ~e);
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_pattern();
    test_toggle_hold();
    test_between_edges();
    test_async_reset();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
